// File: rtl/line_bank_scheduler.sv
// Bank scheduler for the RX->TX dual-port line buffer: hands completed banks to TX in FIFO order
// and flags overrun/underrun. Optional macro UNDERRUN_REPEAT_EN repeats the last line on underrun.
module line_bank_scheduler #(
    parameter  int BANKS      = 2,
    parameter  int LINE_WORDS = 8192,
    parameter  int ADDR_W     = 14,
    parameter  int CNT_W      = 8,
    localparam int BANK_W     = $clog2(BANKS)
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              FRAME_SYNC,
    input  logic              WR_DONE,
    input  logic              RD_START,
    input  logic              RD_DONE,
    output logic [BANK_W-1:0] WR_BANK,
    output logic [ADDR_W-1:0] WR_BASE,
    output logic [BANK_W-1:0] RD_BANK,
    output logic [ADDR_W-1:0] RD_BASE,
    output logic              RD_VALID,
    output logic [BANK_W:0]   FILL,
    output logic              OVERRUN,
    output logic              UNDERRUN,
    output logic [CNT_W-1:0]  OVR_CNT,
    output logic [CNT_W-1:0]  UND_CNT,
    output logic              RD_STATE_DBG
);

    typedef enum logic {R_IDLE = 1'b0, R_ACTIVE = 1'b1} r_state_e;

    r_state_e          state_q, state_d;
    logic [BANK_W-1:0] head_q, head_d;
    logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
    logic [BANK_W-1:0] rd_bank_q, rd_bank_d;
    logic [ADDR_W-1:0] wr_base_q, wr_base_d;
    logic [ADDR_W-1:0] rd_base_q, rd_base_d;
    logic              rd_valid_q, rd_valid_d;
    logic [BANK_W:0]   fill_q, fill_d;
    logic              ovr_q, ovr_d;
    logic              und_q, und_d;
    logic [CNT_W-1:0]  ovr_cnt_q, ovr_cnt_d;
    logic [CNT_W-1:0]  und_cnt_q, und_cnt_d;
    logic              release_bank;
    logic [BANK_W:0]   fill_eff;

    function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
        return (b == BANK_W'(BANKS - 1)) ? '0 : b + BANK_W'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] base_of(input logic [BANK_W-1:0] b);
        return ADDR_W'(b) * ADDR_W'(LINE_WORDS);
    endfunction

    always_comb begin
        state_d      = state_q;
        head_d       = head_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        rd_valid_d   = rd_valid_q;
        fill_d       = fill_q;
        ovr_d        = 1'b0;
        und_d        = 1'b0;
        ovr_cnt_d    = ovr_cnt_q;
        und_cnt_d    = und_cnt_q;
        release_bank = 1'b0;
        fill_eff     = fill_q;

        if (FRAME_SYNC) begin
            state_d    = R_IDLE;
            head_d     = '0;
            wr_bank_d  = '0;
            rd_valid_d = 1'b0;
            fill_d     = '0;
        end else begin
            case (state_q)
                R_IDLE: begin
                    if (RD_START) begin
                        if (fill_q != '0) begin
                            rd_bank_d  = head_q;
                            rd_valid_d = 1'b1;
                            state_d    = R_ACTIVE;
                        end else begin
                            und_d = 1'b1;
                            if (und_cnt_q != '1) und_cnt_d = und_cnt_q + CNT_W'(1);
`ifdef UNDERRUN_REPEAT_EN
                            rd_valid_d = 1'b1;
`else
                            rd_valid_d = 1'b0;
`endif
                        end
                    end
                end
                R_ACTIVE: begin
                    if (RD_DONE) begin
                        release_bank = 1'b1;
                        head_d       = bank_inc(head_q);
                        rd_valid_d   = 1'b0;
                        state_d      = R_IDLE;
                    end
                end
                default: state_d = R_IDLE;
            endcase

            // A release in this same cycle frees room for the incoming bank.
            fill_eff = fill_q - (BANK_W + 1)'(release_bank);
            fill_d   = fill_eff;
            if (WR_DONE) begin
                if (fill_eff < (BANK_W + 1)'(BANKS - 1)) begin
                    wr_bank_d = bank_inc(wr_bank_q);
                    fill_d    = fill_eff + (BANK_W + 1)'(1);
                end else begin
                    ovr_d = 1'b1;
                    if (ovr_cnt_q != '1) ovr_cnt_d = ovr_cnt_q + CNT_W'(1);
                end
            end
        end

        wr_base_d = base_of(wr_bank_d);
        rd_base_d = base_of(rd_bank_d);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= R_IDLE;
            head_q     <= '0;
            wr_bank_q  <= '0;
            rd_bank_q  <= '0;
            wr_base_q  <= '0;
            rd_base_q  <= '0;
            rd_valid_q <= 1'b0;
            fill_q     <= '0;
            ovr_q      <= 1'b0;
            und_q      <= 1'b0;
            ovr_cnt_q  <= '0;
            und_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            wr_base_q  <= wr_base_d;
            rd_base_q  <= rd_base_d;
            rd_valid_q <= rd_valid_d;
            fill_q     <= fill_d;
            ovr_q      <= ovr_d;
            und_q      <= und_d;
            ovr_cnt_q  <= ovr_cnt_d;
            und_cnt_q  <= und_cnt_d;
        end
    end

    assign WR_BANK      = wr_bank_q;
    assign WR_BASE      = wr_base_q;
    assign RD_BANK      = rd_bank_q;
    assign RD_BASE      = rd_base_q;
    assign RD_VALID     = rd_valid_q;
    assign FILL         = fill_q;
    assign OVERRUN      = ovr_q;
    assign UNDERRUN     = und_q;
    assign OVR_CNT      = ovr_cnt_q;
    assign UND_CNT      = und_cnt_q;
    assign RD_STATE_DBG = state_q;

endmodule

// File: tb/tb_line_bank_scheduler.sv
// Bench for line_bank_scheduler: vector table on a 2-bank instance, hand sequences on a 4-bank one.
module tb_line_bank_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 2-bank instance, 8192-word lines
    logic        a_rst = 1'b1, a_fs = 1'b0, a_wd = 1'b0, a_rs = 1'b0, a_rd = 1'b0;
    logic [0:0]  a_wb, a_rb;
    logic [13:0] a_wbase, a_rbase;
    logic        a_v, a_o, a_u, a_st;
    logic [1:0]  a_f;
    logic [7:0]  a_oc, a_uc;

    line_bank_scheduler #(.BANKS(2), .LINE_WORDS(8192), .ADDR_W(14), .CNT_W(8)) dut2 (
        .CLK(clk), .RESET(a_rst), .FRAME_SYNC(a_fs), .WR_DONE(a_wd), .RD_START(a_rs),
        .RD_DONE(a_rd), .WR_BANK(a_wb), .WR_BASE(a_wbase), .RD_BANK(a_rb), .RD_BASE(a_rbase),
        .RD_VALID(a_v), .FILL(a_f), .OVERRUN(a_o), .UNDERRUN(a_u), .OVR_CNT(a_oc),
        .UND_CNT(a_uc), .RD_STATE_DBG(a_st)
    );

    // 4-bank instance, 4096-word lines
    logic        b_rst = 1'b1, b_fs = 1'b0, b_wd = 1'b0, b_rs = 1'b0, b_rd = 1'b0;
    logic [1:0]  b_wb, b_rb;
    logic [13:0] b_wbase, b_rbase;
    logic        b_v, b_o, b_u, b_st;
    logic [2:0]  b_f;
    logic [7:0]  b_oc, b_uc;

    line_bank_scheduler #(.BANKS(4), .LINE_WORDS(4096), .ADDR_W(14), .CNT_W(8)) dut4 (
        .CLK(clk), .RESET(b_rst), .FRAME_SYNC(b_fs), .WR_DONE(b_wd), .RD_START(b_rs),
        .RD_DONE(b_rd), .WR_BANK(b_wb), .WR_BASE(b_wbase), .RD_BANK(b_rb), .RD_BASE(b_rbase),
        .RD_VALID(b_v), .FILL(b_f), .OVERRUN(b_o), .UNDERRUN(b_u), .OVR_CNT(b_oc),
        .UND_CNT(b_uc), .RD_STATE_DBG(b_st)
    );

`ifdef UNDERRUN_REPEAT_EN
    localparam int REP = 1;
`else
    localparam int REP = 0;
`endif

    typedef struct {
        int rst, fs, wd, rs, rd;
        int wb, rb, v, st, f, o, u, oc, uc;
    } vec_t;

    vec_t vecs[21];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Pulses are driven on the falling edge and cleared 1 ns after the rising edge.
    task automatic cyc_a(input int rst, input int fs, input int wd, input int rs, input int rd);
        @(negedge clk);
        a_rst = rst[0]; a_fs = fs[0]; a_wd = wd[0]; a_rs = rs[0]; a_rd = rd[0];
        @(posedge clk);
        #1;
        a_rst = 1'b0; a_fs = 1'b0; a_wd = 1'b0; a_rs = 1'b0; a_rd = 1'b0;
    endtask

    task automatic cyc_b(input int rst, input int fs, input int wd, input int rs, input int rd);
        @(negedge clk);
        b_rst = rst[0]; b_fs = fs[0]; b_wd = wd[0]; b_rs = rs[0]; b_rd = rd[0];
        @(posedge clk);
        #1;
        b_rst = 1'b0; b_fs = 1'b0; b_wd = 1'b0; b_rs = 1'b0; b_rd = 1'b0;
    endtask

    task automatic chk_b(input string tag, input int wb, input int rb, input int v,
                         input int f, input int o, input int oc);
        n_vec++;
        chk({tag, " wr_bank"}, int'(b_wb), wb);
        chk({tag, " wr_base"}, int'(b_wbase), wb * 4096);
        chk({tag, " rd_bank"}, int'(b_rb), rb);
        chk({tag, " rd_base"}, int'(b_rbase), rb * 4096);
        chk({tag, " rd_valid"}, int'(b_v), v);
        chk({tag, " fill"}, int'(b_f), f);
        chk({tag, " overrun"}, int'(b_o), o);
        chk({tag, " ovr_cnt"}, int'(b_oc), oc);
    endtask

    initial begin
        //            rst fs wd rs rd  wb rb v    st f  o  u  oc uc
        vecs[0]  = '{1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 1, 0, 0,  1, 0, 0,   0, 1, 0, 0, 0, 0};
        vecs[3]  = '{0, 0, 0, 1, 0,  1, 0, 1,   1, 1, 0, 0, 0, 0};
        vecs[4]  = '{0, 0, 0, 0, 1,  1, 0, 0,   0, 0, 0, 0, 0, 0};
        vecs[5]  = '{1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0};
        vecs[6]  = '{0, 0, 1, 0, 0,  1, 0, 0,   0, 1, 0, 0, 0, 0};
        vecs[7]  = '{0, 0, 1, 0, 0,  1, 0, 0,   0, 1, 1, 0, 1, 0};
        vecs[8]  = '{0, 0, 0, 0, 0,  1, 0, 0,   0, 1, 0, 0, 1, 0};
        vecs[9]  = '{0, 0, 0, 1, 0,  1, 0, 1,   1, 1, 0, 0, 1, 0};
        vecs[10] = '{0, 0, 1, 0, 1,  0, 0, 0,   0, 1, 0, 0, 1, 0};
        vecs[11] = '{0, 0, 0, 1, 0,  0, 1, 1,   1, 1, 0, 0, 1, 0};
        vecs[12] = '{0, 0, 0, 1, 0,  0, 1, 1,   1, 1, 0, 0, 1, 0};
        vecs[13] = '{0, 0, 0, 0, 1,  0, 1, 0,   0, 0, 0, 0, 1, 0};
        vecs[14] = '{0, 0, 0, 0, 1,  0, 1, 0,   0, 0, 0, 0, 1, 0};
        vecs[15] = '{1, 0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0, 0, 0};
        vecs[16] = '{0, 0, 0, 1, 0,  0, 0, REP, 0, 0, 0, 1, 0, 1};
        vecs[17] = '{0, 0, 0, 0, 0,  0, 0, REP, 0, 0, 0, 0, 0, 1};
        vecs[18] = '{0, 0, 1, 1, 0,  1, 0, REP, 0, 1, 0, 1, 0, 2};
        vecs[19] = '{0, 0, 0, 1, 0,  1, 0, 1,   1, 1, 0, 0, 0, 2};
        vecs[20] = '{0, 1, 0, 0, 1,  0, 0, 0,   0, 0, 0, 0, 0, 2};

        for (int i = 0; i < 21; i++) begin
            string t;
            cyc_a(vecs[i].rst, vecs[i].fs, vecs[i].wd, vecs[i].rs, vecs[i].rd);
            n_vec++;
            t = $sformatf("v%0d", i);
            chk({t, " wr_bank"},  int'(a_wb),    vecs[i].wb);
            chk({t, " wr_base"},  int'(a_wbase), vecs[i].wb * 8192);
            chk({t, " rd_bank"},  int'(a_rb),    vecs[i].rb);
            chk({t, " rd_base"},  int'(a_rbase), vecs[i].rb * 8192);
            chk({t, " rd_valid"}, int'(a_v),     vecs[i].v);
            chk({t, " state"},    int'(a_st),    vecs[i].st);
            chk({t, " fill"},     int'(a_f),     vecs[i].f);
            chk({t, " overrun"},  int'(a_o),     vecs[i].o);
            chk({t, " underrun"}, int'(a_u),     vecs[i].u);
            chk({t, " ovr_cnt"},  int'(a_oc),    vecs[i].oc);
            chk({t, " und_cnt"},  int'(a_uc),    vecs[i].uc);
        end

        // Underrun counter saturation
        cyc_a(1, 0, 0, 0, 0);
        for (int i = 1; i <= 300; i++) begin
            cyc_a(0, 0, 0, 1, 0);
            if (i == 254 || i == 255 || i == 300) begin
                n_vec++;
                chk($sformatf("sat%0d und_cnt", i), int'(a_uc), (i < 255) ? i : 255);
                chk($sformatf("sat%0d underrun", i), int'(a_u), 1);
            end
        end

        // Four banks: fill to the limit, overrun, then flush with a concurrent write
        cyc_b(1, 0, 0, 0, 0); chk_b("b_rst",  0, 0, 0, 0, 0, 0);
        cyc_b(0, 0, 1, 0, 0); chk_b("b_wr1",  1, 0, 0, 1, 0, 0);
        cyc_b(0, 0, 1, 0, 0); chk_b("b_wr2",  2, 0, 0, 2, 0, 0);
        cyc_b(0, 0, 1, 0, 0); chk_b("b_wr3",  3, 0, 0, 3, 0, 0);
        cyc_b(0, 0, 1, 0, 0); chk_b("b_ovr",  3, 0, 0, 3, 1, 1);
        cyc_b(0, 1, 1, 0, 0); chk_b("b_fs",   0, 0, 0, 0, 0, 1);
        cyc_b(0, 0, 1, 0, 0); chk_b("b_wr4",  1, 0, 0, 1, 0, 1);
        cyc_b(0, 0, 1, 0, 0); chk_b("b_wr5",  2, 0, 0, 2, 0, 1);
        cyc_b(0, 0, 0, 1, 0); chk_b("b_rs1",  2, 0, 1, 2, 0, 1);
        cyc_b(0, 0, 0, 0, 1); chk_b("b_rd1",  2, 0, 0, 1, 0, 1);
        cyc_b(0, 0, 0, 1, 0); chk_b("b_rs2",  2, 1, 1, 1, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
